// File: rtl/risc_ctrl_pkg.sv
// Shared vocabulary for the RV32I-subset multicycle controller: FSM states,
// instruction names/types (also used by the verification monitor), datapath
// select encodings, trap causes, opcode constants and the control-word struct.
package risc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALRADR, S_JALRPC, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_AND, I_OR, I_ADDI, I_ANDI, I_ORI,
    I_LW, I_SW, I_BEQ, I_BNE, I_JAL, I_JALR, I_ILLEGAL
  } ins_name_e;

  typedef enum logic [2:0] {T_R, T_I, T_S, T_B, T_J} ins_type_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011
  } alu_ctl_e;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {SA_PC = 2'b00, SA_OLDPC = 2'b01, SA_RS1 = 2'b10} src_a_e;
  typedef enum logic [1:0] {SB_RS2 = 2'b00, SB_IMM = 2'b01, SB_FOUR = 2'b10} src_b_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALU = 2'b10} res_src_e;
  typedef enum logic [1:0] {CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10} cause_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // One cycle's worth of datapath control.
  typedef struct packed {
    logic     mem_req;
    logic     mem_write;
    logic     adr_src;
    logic     ir_write;
    logic     pc_write;
    logic     reg_write;
    src_a_e   alu_src_a;
    src_b_e   alu_src_b;
    alu_ctl_e alu_control;
    imm_src_e imm_src;
    res_src_e result_src;
  } ctrl_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational instruction classifier.
//   instr       : 32-bit instruction register
//   ins_name    : decoded mnemonic (I_ILLEGAL when not in the supported subset)
//   alu_control : ALU operation the instruction's execute step needs
//   legal       : instruction is in the supported subset
module rv_ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ins_name_e   ins_name,
  output alu_ctl_e    alu_control,
  output logic        legal
);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // register/immediate fields are consumed by the datapath, not here
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ins_name = I_ILLEGAL;
    case (opcode)
      OP_R: begin
        if      (f7 == 7'b0000000 && f3 == 3'b000) ins_name = I_ADD;
        else if (f7 == 7'b0100000 && f3 == 3'b000) ins_name = I_SUB;
        else if (f7 == 7'b0000000 && f3 == 3'b111) ins_name = I_AND;
        else if (f7 == 7'b0000000 && f3 == 3'b110) ins_name = I_OR;
      end
      OP_I: begin
        case (f3)
          3'b000:  ins_name = I_ADDI;
          3'b111:  ins_name = I_ANDI;
          3'b110:  ins_name = I_ORI;
          default: ins_name = I_ILLEGAL;
        endcase
      end
      OP_LOAD:   if (f3 == 3'b010) ins_name = I_LW;
      OP_STORE:  if (f3 == 3'b010) ins_name = I_SW;
      OP_BRANCH: begin
        if      (f3 == 3'b000) ins_name = I_BEQ;
        else if (f3 == 3'b001) ins_name = I_BNE;
      end
      OP_JAL:    ins_name = I_JAL;
      OP_JALR:   if (f3 == 3'b000) ins_name = I_JALR;
      default:   ins_name = I_ILLEGAL;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (ins_name)
      I_SUB, I_BEQ, I_BNE: alu_control = ALU_SUB;
      I_AND, I_ANDI:       alu_control = ALU_AND;
      I_OR,  I_ORI:        alu_control = ALU_OR;
      default:             alu_control = ALU_ADD;
    endcase
  end

  assign legal = (ins_name != I_ILLEGAL);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle main controller for the RV32I-subset core.
//   clk, rst_n        : clock (rising edge), async active-low reset
//   instr, zero       : instruction register, ALU zero flag
//   mem_ready         : memory finishes the current access this cycle
//   mem_req/mem_write : memory request / store qualifier
//   adr_src, ir_write, pc_write, reg_write, alu_src_a/b, alu_control,
//   imm_src, result_src : datapath selects and strobes
//   trap, trap_cause  : sticky halt and its reason
//   instret           : retired-instruction count (wraps)
module rv_multicycle_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_control,
  output logic [1:0]           imm_src,
  output logic [1:0]           result_src,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Trap is taken on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  localparam logic [WCNT_W-1:0] WCNT_LAST = (TIMEOUT_CYCLES > 0) ? WCNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e            state, state_n;
  ctrl_t             c;
  cause_e            cause_n, cause_q;
  logic [WCNT_W-1:0] wait_cnt;
  logic              retire, tmo_hit;
  ins_name_e         ins_name;
  alu_ctl_e          dec_alu;
  logic              legal;

  rv_ctrl_decode u_dec (
    .instr       (instr),
    .ins_name    (ins_name),
    .alu_control (dec_alu),
    .legal       (legal)
  );

  // Only consulted in memory-wait states; mem_ready in the same cycle wins.
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && !mem_ready && (wait_cnt == WCNT_LAST);

  always_comb begin
    state_n = state;
    c       = '0;
    cause_n = CAUSE_NONE;
    retire  = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        c.mem_req = 1'b1; c.alu_src_b = SB_FOUR; c.result_src = RES_ALU;
        if (mem_ready) begin
          c.ir_write = 1'b1; c.pc_write = 1'b1; state_n = S_DECODE;
        end else if (tmo_hit) begin
          state_n = S_TRAP; cause_n = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        // ALUOut <= oldPC + imm: the branch/jump target for later states
        c.alu_src_a = SA_OLDPC; c.alu_src_b = SB_IMM;
        if (ins_name == I_JAL) c.imm_src = IMM_J;
        else                   c.imm_src = IMM_B;
        if (!legal) begin
          state_n = S_TRAP; cause_n = CAUSE_ILLEGAL;
        end else begin
          case (ins_name)
            I_LW, I_SW:                 state_n = S_MEMADR;
            I_ADD, I_SUB, I_AND, I_OR:  state_n = S_EXECR;
            I_ADDI, I_ANDI, I_ORI:      state_n = S_EXECI;
            I_JAL:                      state_n = S_JAL;
            I_JALR:                     state_n = S_JALRADR;
            I_BEQ, I_BNE:               state_n = S_BRANCH;
            default: begin state_n = S_TRAP; cause_n = CAUSE_ILLEGAL; end
          endcase
        end
      end
      S_MEMADR: begin
        c.alu_src_a = SA_RS1; c.alu_src_b = SB_IMM;
        if (ins_name == I_SW) begin c.imm_src = IMM_S; state_n = S_MEMWRITE; end
        else                  begin c.imm_src = IMM_I; state_n = S_MEMREAD;  end
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1; c.adr_src = 1'b1;
        if (mem_ready)    state_n = S_MEMWB;
        else if (tmo_hit) begin state_n = S_TRAP; cause_n = CAUSE_TIMEOUT; end
      end
      S_MEMWB: begin
        c.result_src = RES_RDATA; c.reg_write = 1'b1; retire = 1'b1; state_n = S_FETCH;
      end
      S_MEMWRITE: begin
        c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1;
        if (mem_ready)    begin retire = 1'b1; state_n = S_FETCH; end
        else if (tmo_hit) begin state_n = S_TRAP; cause_n = CAUSE_TIMEOUT; end
      end
      S_EXECR: begin
        c.alu_src_a = SA_RS1; c.alu_src_b = SB_RS2; c.alu_control = dec_alu; state_n = S_ALUWB;
      end
      S_EXECI: begin
        c.alu_src_a = SA_RS1; c.alu_src_b = SB_IMM; c.imm_src = IMM_I;
        c.alu_control = dec_alu; state_n = S_ALUWB;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT; c.reg_write = 1'b1; retire = 1'b1; state_n = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = SA_RS1; c.alu_src_b = SB_RS2; c.alu_control = ALU_SUB;
        c.result_src = RES_ALUOUT;
        c.pc_write = (ins_name == I_BNE) ? !zero : zero;
        retire = 1'b1; state_n = S_FETCH;
      end
      S_JAL: begin
        // PC <= target held in ALUOut while the ALU forms the link value
        c.alu_src_a = SA_OLDPC; c.alu_src_b = SB_FOUR; c.result_src = RES_ALUOUT;
        c.pc_write = 1'b1; state_n = S_ALUWB;
      end
      S_JALRADR: begin
        c.alu_src_a = SA_RS1; c.alu_src_b = SB_IMM; c.imm_src = IMM_I; state_n = S_JALRPC;
      end
      S_JALRPC: begin
        c.alu_src_a = SA_OLDPC; c.alu_src_b = SB_FOUR; c.result_src = RES_ALUOUT;
        c.pc_write = 1'b1; state_n = S_ALUWB;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cause_q  <= CAUSE_NONE;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= state_n;
      if (state != S_TRAP && state_n == S_TRAP) cause_q <= cause_n;
      if (c.mem_req && !mem_ready && state_n == state) wait_cnt <= wait_cnt + 1'b1;
      else                                             wait_cnt <= '0;
      if (retire) instret <= instret + 1'b1;
    end
  end

  assign mem_req     = c.mem_req;
  assign mem_write   = c.mem_write;
  assign adr_src     = c.adr_src;
  assign ir_write    = c.ir_write;
  assign pc_write    = c.pc_write;
  assign reg_write   = c.reg_write;
  assign alu_src_a   = c.alu_src_a;
  assign alu_src_b   = c.alu_src_b;
  assign alu_control = c.alu_control;
  assign imm_src     = c.imm_src;
  assign result_src  = c.result_src;
  assign trap        = (state == S_TRAP);
  assign trap_cause  = cause_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle main controller for the RV32I subset core: ADD, SUB, AND, OR, ADDI, ANDI, ORI, LW, SW, BEQ, BNE, JAL, JALR.
- Sequences a shared-ALU, single-port-memory datapath through fetch, decode, execute, memory and writeback states.
- Drives all mux selects and write strobes.
- Handles memory wait states via a req/ready handshake, and traps on illegal opcodes or memory timeout.
- Reports a retired-instruction count for the UVM scoreboard.

Parameters:
TIMEOUT_CYCLES, 0, max cycles mem_req may wait for mem_ready; 0 disables the timeout.
INSTRET_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction register contents (valid from DECODE onward)
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  access is a store (only with mem_req)
adr_src  out  1  0: PC, 1: ALUOut
ir_write  out  1  latch instr and oldPC
pc_write  out  1  PC update strobe
reg_write  out  1  regfile write to rd
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or
imm_src  out  2  00 I, 01 S, 10 B, 11 J
result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
trap  out  1  sticky; core halted
trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout
instret  out  INSTRET_W  retired instruction count

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE; all strobes and selects 0; trap=0, trap_cause=00, instret=0, wait counter=0.
  - Reset mid-access drops mem_req immediately. No instruction completes; instret is not incremented.
- Outputs are Moore (decoded from state), except pc_write/ir_write in FETCH and pc_write in BRANCH.
- IDLE: unconditionally to FETCH next cycle.
- FETCH: mem_req=1, adr_src=0, a=PC, b=4, add, result_src=10.
  - On mem_ready: ir_write=1, pc_write=1 in that same cycle; go to DECODE.
  - Otherwise stay, with outputs held stable.
- DECODE: a=oldPC, b=imm, add; imm_src=J for JAL, else B (ALUOut=branch/jump target).
  - Next state by opcode: LW/SW → MEMADR; R → EXECR; I-ALU → EXECI; JAL → JAL; JALR → JALRADR; BEQ/BNE → BRANCH.
  - Undecodable opcode/funct → TRAP with cause 01.
- MEMADR: a=rs1, b=imm, imm_src=I (LW) or S (SW), add. Next: MEMREAD (LW) or MEMWRITE (SW).
- MEMREAD: mem_req=1, adr_src=1; wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1; retire → FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready retire → FETCH.
- EXECR: a=rs1, b=rs2, alu_control from funct7/funct3 → ALUWB.
- EXECI: a=rs1, b=imm, imm_src=I, alu_control from funct3 → ALUWB.
- ALUWB: result_src=00, reg_write=1; retire → FETCH.
- BRANCH: a=rs1, b=rs2, sub, result_src=00.
  - pc_write = zero for BEQ, !zero for BNE.
  - Retire → FETCH.
- JAL: a=oldPC, b=4, add, result_src=00, pc_write=1 → ALUWB (rd=PC+4).
- JALRADR: a=rs1, b=imm, imm_src=I, add → JALRPC. The datapath clears bit 0 of the target.
- JALRPC: a=oldPC, b=4, result_src=00, pc_write=1 → ALUWB.
- Latency, excluding memory waits: R/I/JAL 4 cycles; LW and JALR 5; SW 4; branches 3.
- Retire: instret increments by 1 on leaving the final state of an instruction, and wraps at all-ones.
- Timeout: the counter increments each cycle mem_req=1 && !mem_ready and clears on mem_ready or a state change.
  - When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, go to TRAP with cause 10.
  - A mem_ready arriving in that same cycle wins; no trap.
- TRAP: all strobes 0, trap=1. Exit only by reset.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package risc_ctrl_pkg holds:
  - state enum;
  - ALU control, imm_src, src-select and trap-cause encodings;
  - opcode constants.
- It reuses the existing ins_name/ins_type enums so the monitor and the RTL share one vocabulary.
- One combinational sub-module, rv_ctrl_decode: instr → ins_name, alu_control, legal flag.

Test Plan:
- Reset release, ADD x3,x1,x2 (0x002081B3) with mem_ready tied 1 → IDLE, FETCH, DECODE, EXECR (alu_control=000), ALUWB (reg_write=1) → instret=1 after 4 cycles past IDLE.
- LW x5,8(x0) (0x00802283) with 3 wait cycles in FETCH and 2 in MEMREAD:
  - mem_req held for 4 and 3 cycles;
  - ir_write pulses once;
  - MEMWB asserts result_src=01, reg_write=1.
- BEQ (0x00208463): zero=1 → pc_write=1 in BRANCH. Repeat with zero=0 → pc_write=0. BNE with zero=0 → pc_write=1. Each takes 3 cycles.
- JALR x1,0(x2) (0x000100E7) → states DECODE, JALRADR, JALRPC (pc_write=1), ALUWB (reg_write=1, result_src=00).
- Opcode 0x7F (0x0000007F) → TRAP: trap=1, trap_cause=01, all strobes 0 for 20 cycles. Assert rst_n=0 mid-TRAP → trap=0 asynchronously.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → trap_cause=10 after 4 wait cycles. With mem_ready=1 exactly on the 4th cycle → normal DECODE, no trap.
